// File: rtl/score_judge.sv
// score_judge: level-scoring engine for the piano game.
// Latches a level pattern, counts its set bits one row per cycle to form the
// target note count, then judges player scores against target minus a
// saturating tolerance while tracking lives, per-level win and game-over.
module score_judge #(
  parameter int KEYS      = 12,
  parameter int ROWS      = 6,
  parameter int SCORE_W   = 5,
  parameter int LIVES     = 3,
  parameter int LIVES_W   = 2,
  parameter int TOLERANCE = 2,
  localparam int CNT_W    = $clog2(ROWS*KEYS+1)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [ROWS*KEYS-1:0]   level_codes,
  input  logic                   load,
  input  logic [SCORE_W-1:0]     input_score,
  input  logic                   check,
  output logic                   busy,
  output logic [CNT_W-1:0]       target,
  output logic                   result_valid,
  output logic                   win,
  output logic [LIVES_W-1:0]     lives,
  output logic                   game_over
);

  // Row index must also reach ROWS, which marks "all rows summed".
  localparam int RIDX_W = $clog2(ROWS+1);
  localparam int POP_W  = $clog2(KEYS+1);
  localparam int CMP_W  = (SCORE_W > CNT_W+1) ? SCORE_W : CNT_W+1;

  localparam logic [CNT_W:0]        TOL_C      = (CNT_W+1)'(TOLERANCE);
  localparam logic [RIDX_W-1:0]     LAST_IDX_C = RIDX_W'(ROWS);
  localparam logic [LIVES_W-1:0]    LIVES_C    = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0]    ONE_LIFE_C = LIVES_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_READY = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Number of set bits in one pattern row.
  function automatic logic [POP_W-1:0] popcount(input logic [KEYS-1:0] bits);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEYS; i++) begin
      cnt = cnt + POP_W'(bits[i]);
    end
    return cnt;
  endfunction

  state_e                 state_q;
  logic [ROWS*KEYS-1:0]   shadow_q;
  logic [CNT_W-1:0]       acc_q;
  logic [RIDX_W-1:0]      row_idx_q;
  logic [CNT_W-1:0]       target_q;
  logic                   busy_q;
  logic                   result_valid_q;
  logic                   win_q;
  logic [LIVES_W-1:0]     lives_q;
  logic                   game_over_q;

  logic [KEYS-1:0]        row_bits_s;
  logic [CNT_W-1:0]       acc_d;
  logic [CNT_W:0]         target_ext_s;
  logic [CNT_W:0]         threshold_s;
  logic                   pass_s;
  logic [LIVES_W-1:0]     lives_d;

  // Select the shadow row currently being summed (zero once past the last row).
  always_comb begin
    row_bits_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_bits_s = (row_idx_q == RIDX_W'(r)) ? shadow_q[r*KEYS +: KEYS] : row_bits_s;
    end
  end

  // Accumulator step, saturating threshold, pass decision and next life count.
  always_comb begin
    acc_d        = acc_q + CNT_W'(popcount(row_bits_s));
    target_ext_s = {1'b0, target_q};
    if (target_ext_s >= TOL_C) begin
      threshold_s = target_ext_s - TOL_C;
    end else begin
      threshold_s = '0;
    end
    pass_s = (CMP_W'(input_score) >= CMP_W'(threshold_s));
    if (lives_q != '0) begin
      lives_d = lives_q - ONE_LIFE_C;
    end else begin
      lives_d = '0;
    end
  end

  // Main control FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      shadow_q       <= '0;
      acc_q          <= '0;
      row_idx_q      <= '0;
      target_q       <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      lives_q        <= LIVES_C;
      game_over_q    <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (load) begin
            shadow_q  <= level_codes;
            acc_q     <= '0;
            row_idx_q <= '0;
            win_q     <= 1'b0;
            state_q   <= ST_COUNT;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_COUNT: begin
          // One row per cycle; the cycle after the last row commits the sum.
          if (row_idx_q == LAST_IDX_C) begin
            target_q <= acc_q;
            busy_q   <= 1'b0;
            state_q  <= ST_READY;
          end else begin
            acc_q     <= acc_d;
            row_idx_q <= row_idx_q + RIDX_W'(1);
            busy_q    <= 1'b1;
            state_q   <= ST_COUNT;
          end
        end
        ST_READY: begin
          busy_q <= 1'b0;
          if (load) begin
            // Restart takes priority over a simultaneous check.
            shadow_q  <= level_codes;
            acc_q     <= '0;
            row_idx_q <= '0;
            win_q     <= 1'b0;
            state_q   <= ST_COUNT;
          end else if (check && !result_valid_q) begin
            // A held check is judged only after result_valid has dropped.
            result_valid_q <= 1'b1;
            if (pass_s) begin
              win_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              win_q   <= 1'b0;
              lives_q <= lives_d;
              if (lives_q <= ONE_LIFE_C) begin
                game_over_q <= 1'b1;
                state_q     <= ST_OVER;
              end else begin
                state_q     <= ST_READY;
              end
            end
          end else begin
            state_q <= ST_READY;
          end
        end
        ST_OVER: begin
          busy_q      <= 1'b0;
          game_over_q <= 1'b1;
          lives_q     <= '0;
          state_q     <= ST_OVER;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign target       = target_q;
  assign result_valid = result_valid_q;
  assign win          = win_q;
  assign lives        = lives_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_score_judge.sv
// Bench for score_judge: directed steps plus randomized levels, checked against
// a behavioural model built from the game rules (popcount target, saturating
// tolerance, lives/win/game-over bookkeeping).
module tb_score_judge;

  localparam int KEYS      = 12;
  localparam int ROWS      = 6;
  localparam int SCORE_W   = 5;
  localparam int LIVES     = 3;
  localparam int LIVES_W   = 2;
  localparam int TOLERANCE = 2;
  localparam int CNT_W     = $clog2(ROWS*KEYS+1);
  localparam int NBITS     = ROWS*KEYS;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic [NBITS-1:0]   level_codes = '0;
  logic               load = 1'b0;
  logic [SCORE_W-1:0] input_score = '0;
  logic               check = 1'b0;
  logic               busy;
  logic [CNT_W-1:0]   target;
  logic               result_valid;
  logic               win;
  logic [LIVES_W-1:0] lives;
  logic               game_over;

  int errors = 0;
  int checks = 0;

  // Model of the game: 0 = waiting for a level, 1 = level ready, 2 = game over.
  int m_st;
  int m_target;
  int m_lives;
  bit m_win, m_go, m_busy, m_rv;

  score_judge #(
    .KEYS(KEYS), .ROWS(ROWS), .SCORE_W(SCORE_W), .LIVES(LIVES),
    .LIVES_W(LIVES_W), .TOLERANCE(TOLERANCE)
  ) dut (
    .clock(clock), .resetn(resetn), .level_codes(level_codes), .load(load),
    .input_score(input_score), .check(check), .busy(busy), .target(target),
    .result_valid(result_valid), .win(win), .lives(lives), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".busy"},      32'(busy),         32'(m_busy));
    chk({tag, ".target"},    32'(target),       32'(m_target));
    chk({tag, ".rvalid"},    32'(result_valid), 32'(m_rv));
    chk({tag, ".win"},       32'(win),          32'(m_win));
    chk({tag, ".lives"},     32'(lives),        32'(m_lives));
    chk({tag, ".game_over"}, 32'(game_over),    32'(m_go));
  endtask

  function automatic int thr(input int t);
    return (t >= TOLERANCE) ? t - TOLERANCE : 0;
  endfunction

  function automatic logic [NBITS-1:0] rand_codes();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[NBITS-1:0];
  endfunction

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    load = 1'b1;
    check = 1'b1;
    level_codes = rand_codes();
    step;
    m_st = 0; m_target = 0; m_lives = LIVES;
    m_win = 1'b0; m_go = 1'b0; m_busy = 1'b0; m_rv = 1'b0;
    chk_all(tag);
    load = 1'b0;
    check = 1'b0;
    resetn = 1'b1;
    step;
    chk_all({tag, ".idle"});
  endtask

  // Load a level (from idle or ready) and follow the count to completion.
  task automatic load_level(input logic [NBITS-1:0] codes, input bit poke_mid,
                            input bit with_check, input string tag);
    int new_t;
    new_t = $countones(codes);
    level_codes = codes;
    load = 1'b1;
    check = with_check;
    input_score = '0;
    step;
    load = 1'b0;
    check = 1'b0;
    level_codes = rand_codes();
    m_busy = 1'b0; m_win = 1'b0; m_rv = 1'b0;
    chk_all({tag, ".t0"});
    for (int k = 1; k <= ROWS; k++) begin
      if (poke_mid && k == 3) begin
        load = 1'b1;
        level_codes = ~codes;
      end
      step;
      load = 1'b0;
      m_busy = 1'b1;
      chk_all($sformatf("%s.c%0d", tag, k));
    end
    step;
    m_busy = 1'b0;
    m_target = new_t;
    m_st = 1;
    chk_all({tag, ".done"});
  endtask

  // Present one check request; optionally hold it for a second cycle.
  task automatic do_check(input int score, input bit hold, input string tag);
    input_score = SCORE_W'(score);
    check = 1'b1;
    step;
    if (m_st == 1) begin
      m_rv = 1'b1;
      if (score >= thr(m_target)) begin
        m_win = 1'b1;
        m_st = 0;
      end else begin
        m_win = 1'b0;
        m_lives = m_lives - 1;
        if (m_lives == 0) begin
          m_go = 1'b1;
          m_st = 2;
        end
      end
    end else begin
      m_rv = 1'b0;
    end
    chk_all({tag, ".j"});
    if (!hold) check = 1'b0;
    step;
    check = 1'b0;
    m_rv = 1'b0;
    chk_all({tag, ".r"});
  endtask

  initial begin
    logic [NBITS-1:0] c20;
    c20 = {12'h007, 12'h700, 12'h0F0, 12'h070, 12'h00F, 12'h007};

    do_reset("rst");

    // Basic pass at the tolerance boundary, then a check while idle.
    load_level(c20, 1'b0, 1'b0, "ld20");
    chk("tgt20", 32'(target), 32'd20);
    do_check(18, 1'b0, "pass18");
    do_check(5, 1'b0, "idle_chk");

    // One below threshold fails and stays ready.
    load_level(c20, 1'b0, 1'b0, "ld20b");
    do_check(17, 1'b0, "fail17");

    // Load and check together: load wins. Then load mid-count is ignored.
    load_level(c20, 1'b0, 1'b1, "ldchk");
    load_level(c20, 1'b1, 1'b0, "midld");

    // Held check judges only once in two cycles; then pass on last life.
    do_check(0, 1'b1, "hold");
    do_check(18, 1'b0, "pass_last");

    // Exhaust lives from a fresh game.
    do_reset("rst2");
    load_level(c20, 1'b0, 1'b0, "ldgo");
    for (int i = 0; i < 3; i++) do_check(0, 1'b0, $sformatf("miss%0d", i));

    // Game over ignores load and check.
    level_codes = rand_codes();
    load = 1'b1;
    check = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk_all($sformatf("over%0d", i));
    end
    load = 1'b0;
    check = 1'b0;
    do_reset("rst_over");

    // Empty level: threshold saturates at zero, score zero passes.
    load_level('0, 1'b0, 1'b0, "ldzero");
    do_check(0, 1'b0, "zero_pass");

    // Reset in the middle of a count.
    level_codes = c20;
    load = 1'b1;
    step;
    load = 1'b0;
    step;
    step;
    do_reset("rst_mid");

    // Randomized levels with scores near the threshold.
    for (int lv = 0; lv < 25; lv++) begin
      logic [NBITS-1:0] codes;
      codes = rand_codes() & rand_codes();
      if ($urandom_range(0, 3) == 0) codes = codes & rand_codes();
      load_level(codes, 1'b0, 1'b0, $sformatf("rl%0d", lv));
      while (m_st == 1) begin
        int s;
        s = thr(m_target) + int'($urandom_range(0, 6)) - 3;
        if (s < 0) s = 0;
        if (s > 31) s = 31;
        do_check(s, ($urandom_range(0, 3) == 0), $sformatf("rc%0d", lv));
      end
      if (m_st == 2) do_reset($sformatf("rr%0d", lv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
